// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
package fetch_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int unsigned DEFAULT_MEM_SIZE = 1024;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush and reset empty it, storage is never cleared.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_pop;
  logic           do_push;

  assign empty   = (count == '0);
  assign full    = (count == (PW + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: registered PC addresses a combinational imem, fetched words queue up for the consumer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned MEM_SIZE    = DEFAULT_MEM_SIZE,
  parameter logic [63:0] RESET_PC    = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        oob_stall
);

  localparam int unsigned CW        = $clog2(QUEUE_DEPTH) + 1;
  // PC + 3 < MEM_SIZE rewritten as PC < MEM_SIZE - 3 so the compare never overflows.
  localparam logic [63:0] OOB_LIMIT = 64'(MEM_SIZE) - 64'd3;

  logic [63:0]   pc_q;
  logic          in_bounds;
  logic          transfer;
  logic          push;
  logic          q_full;
  logic          q_empty;
  logic [CW-1:0] q_count;
  logic          unused_count;
  fetch_entry_t  head;
  fetch_entry_t  new_entry;

  // Handshake: the head moves to the consumer in any cycle with out_valid & out_ready,
  // and is popped at the closing edge; out_valid never depends on out_ready, and an
  // entry accepted in a redirect cycle still counts as taken (the consumer squashes it).
  assign transfer  = out_valid & out_ready;

  assign imem_addr = pc_q;
  assign in_bounds = (pc_q < OOB_LIMIT);
  assign oob_stall = ~in_bounds;
  assign push      = ~redirect_valid & in_bounds & (~q_full | transfer);

  assign new_entry = '{pc: pc_q, instr: imem_instr};

  assign out_valid = ~q_empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  assign unused_count = ^q_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc & ~64'h3;
    end else if (push) begin
      pc_q <= pc_q + 64'd4;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (new_entry),
    .pop       (transfer),
    .flush     (redirect_valid),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-level reference model checked every cycle plus directed literal checks.
module tb_fetch_unit;

  localparam int unsigned QD  = 4;
  localparam int unsigned MS  = 1024;
  localparam logic [63:0] RPC = 64'h0;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        oob_stall;

  always #5 clk = ~clk;

  fetch_unit #(
    .QUEUE_DEPTH (QD),
    .MEM_SIZE    (MS),
    .RESET_PC    (RPC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .oob_stall      (oob_stall)
  );

  // memory word k holds value k; outside memory the data is undefined
  assign imem_instr = (imem_addr < 64'(MS)) ? imem_addr[33:2] : 'x;

  int tests = 0;
  int fails = 0;

  // scoreboard: expected queue contents {pc, instr} and expected fetch PC
  logic [95:0] exp_q[$];
  logic [63:0] mpc;
  bit          model_ok = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model, advanced on each edge from the inputs held across it
  always @(posedge clk) begin
    bit take;
    bit fetch;
    if (reset) begin
      exp_q.delete();
      mpc      = RPC;
      model_ok = 1'b1;
    end else if (redirect_valid) begin
      exp_q.delete();
      mpc = {redirect_pc[63:2], 2'b00};
    end else begin
      take  = out_ready && (exp_q.size() > 0);
      fetch = (mpc + 64'd3 < 64'(MS)) && ((exp_q.size() < QD) || take);
      if (take) void'(exp_q.pop_front());
      if (fetch) begin
        exp_q.push_back({mpc, mpc[33:2]});
        mpc = mpc + 64'd4;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (model_ok) begin
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("out_pc", out_pc, exp_q[0][95:32]);
        check("out_instr", 64'(out_instr), 64'(exp_q[0][31:0]));
      end
      check("imem_addr", imem_addr, mpc);
      check("oob_stall", 64'(oob_stall), 64'(!(mpc + 64'd3 < 64'(MS))));
      tests++;
      assert (imem_addr[1:0] == 2'b00)
      else begin
        fails++;
        $display("FAIL imem_align: got %b expected 00", imem_addr[1:0]);
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  logic [39:0] ready_pat;

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    out_ready      = 1'b0;
    ready_pat      = 40'hB3_6D_1F_A4_5C;

    repeat (2) cyc();
    sample();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_addr", imem_addr, RPC);
    check("rst_oob", 64'(oob_stall), 64'd0);

    // streaming with consumer always ready
    cyc();
    reset     = 1'b0;
    out_ready = 1'b1;
    sample();
    check("stream_first_empty", 64'(out_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      sample();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_pc", out_pc, 64'(4 * i));
      check("stream_instr", 64'(out_instr), 64'(i));
    end

    // backpressure: queue fills to 4 and the PC parks at 16
    cyc();
    reset = 1'b1;
    cyc();
    reset     = 1'b0;
    out_ready = 1'b0;
    repeat (10) cyc();
    sample();
    check("bp_addr", imem_addr, 64'd16);
    check("bp_head", out_pc, 64'd0);
    check("bp_depth", 64'(exp_q.size()), 64'd4);
    out_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      cyc();
      sample();
      check("drain_pc", out_pc, 64'(4 * i));
    end

    // redirect with three stale entries queued
    cyc();
    reset = 1'b1;
    cyc();
    reset     = 1'b0;
    out_ready = 1'b0;
    repeat (3) cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h40;
    out_ready      = 1'b1;
    sample();
    check("pre_redir_head", out_pc, 64'd0);
    cyc();
    redirect_valid = 1'b0;
    sample();
    check("redir_flush", 64'(out_valid), 64'd0);
    check("redir_addr", imem_addr, 64'h40);
    cyc();
    sample();
    check("redir_pc", out_pc, 64'h40);
    check("redir_instr", 64'(out_instr), 64'h10);
    cyc();
    sample();
    check("redir_next", out_pc, 64'h44);

    // fetch runs off the end of memory
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3F8;
    cyc();
    redirect_valid = 1'b0;
    sample();
    check("edge_oob0", 64'(oob_stall), 64'd0);
    cyc();
    sample();
    check("edge_pc0", out_pc, 64'h3F8);
    check("edge_instr0", 64'(out_instr), 64'hFE);
    cyc();
    sample();
    check("edge_pc1", out_pc, 64'h3FC);
    check("edge_instr1", 64'(out_instr), 64'hFF);
    check("edge_oob1", 64'(oob_stall), 64'd1);
    repeat (3) cyc();
    sample();
    check("edge_drained", 64'(out_valid), 64'd0);
    check("edge_stalled", 64'(oob_stall), 64'd1);
    check("edge_addr", imem_addr, 64'h400);

    // misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 64'h23;
    cyc();
    redirect_valid = 1'b0;
    sample();
    check("align_addr", imem_addr, 64'h20);
    check("align_oob", 64'(oob_stall), 64'd0);
    cyc();
    sample();
    check("align_pc", out_pc, 64'h20);
    check("align_instr", 64'(out_instr), 64'h8);

    // back-to-back redirects, last one wins
    redirect_valid = 1'b1;
    redirect_pc    = 64'h80;
    cyc();
    redirect_pc = 64'h90;
    cyc();
    redirect_valid = 1'b0;
    sample();
    check("b2b_addr", imem_addr, 64'h90);
    check("b2b_empty", 64'(out_valid), 64'd0);
    cyc();
    sample();
    check("b2b_pc", out_pc, 64'h90);

    // irregular consumer; the model checks every cycle
    for (int i = 0; i < 40; i++) begin
      out_ready = ready_pat[i];
      cyc();
    end

    // reset beats a simultaneous redirect with a full queue
    out_ready = 1'b0;
    repeat (6) cyc();
    sample();
    check("full_before_rst", 64'(exp_q.size()), 64'd4);
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    out_ready      = 1'b1;
    cyc();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    sample();
    check("rst_redir_valid", 64'(out_valid), 64'd0);
    check("rst_redir_addr", imem_addr, RPC);
    cyc();
    sample();
    check("rst_redir_pc", out_pc, RPC);

    repeat (2) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: QUEUE_DEPTH, default 4, fetch-queue entries; power of two, >= 2.
REQ-002 Parameter: MEM_SIZE, default 1024, instruction-memory size in bytes; power of two, > 4.
REQ-003 Parameter: RESET_PC, default 64'h0, first fetch address after reset; word-aligned.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 imem_addr  output  64  byte address to the combinational instruction memory; always word-aligned.
REQ-007 imem_instr  input  32  instruction word returned combinationally for imem_addr.
REQ-008 redirect_valid  input  1  branch or jump redirect request.
REQ-009 redirect_pc  input  64  new fetch address; bits [1:0] ignored and treated as 0.
REQ-010 out_valid  output  1  queue head holds a valid instruction.
REQ-011 out_ready  input  1  consumer accepts the head this cycle.
REQ-012 out_instr  output  32  instruction at the queue head.
REQ-013 out_pc  output  64  byte address of out_instr.
REQ-014 oob_stall  output  1  fetch PC is out of bounds; fetching halted.

Function
REQ-015 Registered fetch PC drives imem_addr directly, with no combinational logic between them.
REQ-016 Transfer = out_valid & out_ready; the head is popped at the clock edge ending that cycle.
REQ-017 Push condition (no redirect): PC in bounds (PC+3 < MEM_SIZE) and (count < QUEUE_DEPTH or transfer this cycle).
REQ-018 On push: entry {PC, imem_instr} written at tail; PC <= PC+4.
REQ-019 No push: PC holds.
REQ-020 Full queue with simultaneous pop: push and pop both occur; count unchanged.
REQ-021 Empty queue: out_valid=0; out_instr/out_pc are don't-care; no bypass from imem_instr.
REQ-022 Fetch-to-out latency: an instruction pushed at edge N is visible on out_* in the cycle after edge N.
REQ-023 oob_stall = ~(PC+3 < MEM_SIZE), computed combinationally from the PC register; while it is set, no push occurs, imem_instr is ignored (may be X) and queued entries keep draining.
REQ-024 Redirect (highest priority) at edge: queue flushed (count <= 0), PC <= {redirect_pc[63:2],2'b00}, no push that cycle.
REQ-025 A transfer in a redirect cycle counts as accepted by the handshake; the consumer squashes it.
REQ-026 Redirect to an out-of-bounds PC: flush occurs, then oob_stall=1 until the next in-bounds redirect.
REQ-027 Back-to-back redirects: the last one wins; each flushes.
REQ-028 Queue pointers wrap modulo QUEUE_DEPTH; count ranges 0..QUEUE_DEPTH.
REQ-029 PC arithmetic is 64-bit unsigned; the in-bounds compare is done without overflow (PC >= MEM_SIZE-3 means out of bounds).

Reset
REQ-030 reset held at an edge: PC <= RESET_PC, count and pointers <= 0, out_valid=0, oob_stall reflects RESET_PC.
REQ-031 reset has priority over redirect and transfer; reset mid-stream discards all queued entries.
REQ-032 Queue data storage is not reset.

Structure
REQ-033 Package fetch_pkg holds: fetch_entry_t {pc[63:0], instr[31:0]} and the default MEM_SIZE constant.
REQ-034 One sub-module fetch_queue: synchronous FIFO of fetch_entry_t with push, pop, flush, full, empty and count signals.
REQ-035 The fetch_unit top contains the PC register, the bounds check and the push/redirect control.

Verification
REQ-036 Reset then out_ready=1, memory word k = k: out_pc 0,4,8,... and out_instr 0,1,2,... one per cycle, first at the cycle after reset falls.
REQ-037 out_ready=0 for 10 cycles: exactly 4 entries queued (PC 0..12), imem_addr holds 16; release -> in-order drain, no loss or duplicate.
REQ-038 Redirect to 0x40 while the queue holds 3 entries: next out_pc=0x40, none of the stale entries appear.
REQ-039 Redirect to 0x3F8 with MEM_SIZE=1024: entries 0x3F8 and 0x3FC delivered, then oob_stall=1 and out_valid=0 once the queue drains.
REQ-040 reset asserted with a full queue and redirect_valid=1 at the same edge: next cycle out_valid=0, imem_addr=RESET_PC.
REQ-041 redirect_pc=0x23: fetch resumes at 0x20; imem_addr[1:0]==0 checked by assertion every cycle.
